sprite_line_fetch: RTL

SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

---
 rtl/sprite_line_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sprite_line_fetch.sv
// Sprite line fetch: a double-buffered single-sprite line engine.
// During horizontal blank it fetches one SPR_W-pixel row of the sprite from
// word-addressed memory into the fill buffer. The display buffer feeds a
// registered per-pixel hit test.
// Optional feature macro: SPRITE_HFLIP_EN (honours SPR_HFLIP as a horizontal
// mirror of the displayed row).
module sprite_line_fetch #(
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 32,
  parameter int          ADDR_W      = 20,
  parameter logic [15:0] TRANSPARENT = 16'h0000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              SPR_EN,
  input  logic [9:0]        SPR_X,
  input  logic [9:0]        SPR_Y,
  input  logic [ADDR_W-1:0] SPR_BASE,
  input  logic              SPR_HFLIP,
  input  logic              LINE_START,
  input  logic [9:0]        LINE_Y,
  input  logic [9:0]        VGA_DRAW_X,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_RDATA,
  output logic              VGA_SPRITE_ISOBJ,
  output logic [15:0]       VGA_SPRITE_PIXEL
);

  localparam int             CW       = $clog2(SPR_W);
  localparam logic [CW-1:0]  COL_LAST = CW'(SPR_W - 1);
  localparam logic [10:0]    W11      = 11'(SPR_W);
  localparam logic [10:0]    H11      = 11'(SPR_H);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [1:0]             valid_q, valid_d;     // indexed by physical buffer
  logic                   disp_sel_q, disp_sel_d; // physical buffer on display
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   isobj_q, isobj_d;
  logic [15:0]            pixel_q, pixel_d;
  logic [SPR_W-1:0][15:0] buf0_q, buf1_q;

  // Row of the sprite that covers the upcoming line; bit 10 is the borrow.
  logic [10:0]       row;
  logic              qual;
  logic [ADDR_W-1:0] row_off;
  logic              fill_sel;
  logic              wr_en;

  assign row      = {1'b0, LINE_Y} - {1'b0, SPR_Y};
  assign qual     = SPR_EN & ~row[10] & (row < H11);
  assign row_off  = ADDR_W'(row[9:0]) << CW;
  assign fill_sel = ~disp_sel_q;
  // An ack coinciding with LINE_START belongs to an aborted fetch.
  assign wr_en    = (state_q == FETCH) & MEM_ACK & ~LINE_START;

  // Fetch sequencing, buffer role swap and valid-flag bookkeeping.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    valid_d    = valid_q;
    disp_sel_d = disp_sel_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      FETCH: begin
        if (wr_en) begin
          col_d      = col_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
          if (col_q == COL_LAST) begin
            state_d   = DONE;
            mem_req_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d           = IDLE;
        valid_d[fill_sel] = 1'b1;
      end
      default: ;
    endcase
    // LINE_START overrides everything above, aborting any fetch in flight.
    if (LINE_START) begin
      disp_sel_d          = ~disp_sel_q;
      valid_d             = valid_q;
      valid_d[disp_sel_q] = 1'b0;
      col_d               = '0;
      if (qual) begin
        state_d    = FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = SPR_BASE + row_off;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end
  end

  // Display index, optionally mirrored, and the registered hit test.
  logic [10:0]   off;
  logic [CW-1:0] idx;
  logic [15:0]   pix;
  logic          hit;

  assign off = {1'b0, VGA_DRAW_X} - {1'b0, SPR_X};

`ifdef SPRITE_HFLIP_EN
  assign idx = SPR_HFLIP ? ~off[CW-1:0] : off[CW-1:0];
`else
  logic unused_hflip;
  assign unused_hflip = SPR_HFLIP;
  assign idx          = off[CW-1:0];
`endif

  // Borrow check keeps a right-edge sprite from wrapping onto column 0.
  always_comb begin
    pix     = disp_sel_q ? buf1_q[idx] : buf0_q[idx];
    hit     = valid_q[disp_sel_q] & ~off[10] & (off < W11) & (pix != TRANSPARENT);
    isobj_d = hit;
    pixel_d = hit ? pix : 16'h0000;
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      col_q      <= '0;
      valid_q    <= '0;
      disp_sel_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      isobj_q    <= 1'b0;
      pixel_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      valid_q    <= valid_d;
      disp_sel_q <= disp_sel_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      isobj_q    <= isobj_d;
      pixel_q    <= pixel_d;
    end
  end

  // Line buffer storage; contents need no reset, the valid flags gate use.
  always_ff @(posedge CLK) begin
    if (wr_en && fill_sel)  buf1_q[col_q] <= MEM_RDATA;
    if (wr_en && !fill_sel) buf0_q[col_q] <= MEM_RDATA;
  end

  // Request drops combinationally on LINE_START so an abort is seen that cycle.
  assign MEM_REQ          = mem_req_q & ~LINE_START;
  assign MEM_ADDR         = mem_addr_q;
  assign VGA_SPRITE_ISOBJ = isobj_q;
  assign VGA_SPRITE_PIXEL = pixel_q;

endmodule
